// File: rtl/fifo_pkg.sv
// Shared constants for the FIFO read-side stream stage.
package fifo_pkg;

  localparam int unsigned FIFO_RD_LATENCY    = 1;
  localparam int unsigned FIFO_DEFAULT_WIDTH = 8;

  // Width needed to hold an occupancy count of 0..depth.
  function automatic int unsigned lvl_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/rd_skid_buf.sv
// Circular output buffer that absorbs the FIFO read latency; head entry is a registered output.
module rd_skid_buf
  import fifo_pkg::*;
#(
  parameter int unsigned WIDTH     = FIFO_DEFAULT_WIDTH,
  parameter int unsigned BUF_DEPTH = 2
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              wr_en,
  input  logic [WIDTH-1:0]                  wr_data,
  input  logic                              rd_en,
  output logic [WIDTH-1:0]                  rd_data,
  output logic [lvl_width(BUF_DEPTH)-1:0]   level
);

  localparam int unsigned LVL_W = lvl_width(BUF_DEPTH);
  localparam int unsigned PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(BUF_DEPTH - 1);

  logic [WIDTH-1:0] mem_q [BUF_DEPTH];
  logic [PTR_W-1:0] head_q, tail_q;
  logic [LVL_W-1:0] level_q;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
    return (ptr == LAST_PTR) ? '0 : ptr + 1'b1;
  endfunction

  // Storage is cleared on reset so the head word reads as zero while empty.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < BUF_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      head_q  <= '0;
      tail_q  <= '0;
      level_q <= '0;
    end else begin
      if (wr_en) begin
        mem_q[tail_q] <= wr_data;
        tail_q        <= next_ptr(tail_q);
      end
      if (rd_en) begin
        head_q <= next_ptr(head_q);
      end
      level_q <= level_q + LVL_W'(wr_en) - LVL_W'(rd_en);
    end
  end

  assign rd_data = mem_q[head_q];
  assign level   = level_q;

endmodule

// File: rtl/fifo_rd_stream.sv
// Read-side consumer of the async FIFO: credit-based pop, capture, valid/ready output stream.
// Optional word counter enabled by defining RD_WORD_CNT_EN.
module fifo_rd_stream
  import fifo_pkg::*;
#(
  parameter int unsigned WIDTH     = FIFO_DEFAULT_WIDTH,
  parameter int unsigned BUF_DEPTH = 2,
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                            r_clk,
  input  logic                            reset,
  input  logic [WIDTH-1:0]                r_data,
  input  logic                            r_empty,
  output logic                            destination_r_en,
  output logic [WIDTH-1:0]                out_data,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [lvl_width(BUF_DEPTH)-1:0] buf_level
`ifdef RD_WORD_CNT_EN
  ,
  output logic [CNT_WIDTH-1:0]            word_cnt
`endif
);

  // One extra slot of headroom covers words still in the FIFO read pipeline.
  localparam int unsigned SUM_W = $clog2(BUF_DEPTH + FIFO_RD_LATENCY + 1);

  logic             inflight_q;
  logic             pop;
  logic             accepted;
  logic [SUM_W-1:0] credit_sum;

  assign out_valid  = (buf_level != '0);
  assign pop        = out_valid & out_ready;
  assign credit_sum = SUM_W'(buf_level) + SUM_W'(inflight_q) - SUM_W'(pop);

  assign destination_r_en = reset & ~r_empty & (credit_sum < SUM_W'(BUF_DEPTH));
  assign accepted         = destination_r_en & ~r_empty;

  always_ff @(posedge r_clk or negedge reset) begin
    if (!reset) begin
      inflight_q <= 1'b0;
    end else begin
      inflight_q <= accepted;
    end
  end

  rd_skid_buf #(
    .WIDTH     (WIDTH),
    .BUF_DEPTH (BUF_DEPTH)
  ) u_skid_buf (
    .clk     (r_clk),
    .reset   (reset),
    .wr_en   (inflight_q),
    .wr_data (r_data),
    .rd_en   (pop),
    .rd_data (out_data),
    .level   (buf_level)
  );

`ifdef RD_WORD_CNT_EN
  logic [CNT_WIDTH-1:0] word_cnt_q;

  always_ff @(posedge r_clk or negedge reset) begin
    if (!reset) begin
      word_cnt_q <= '0;
    end else if (pop) begin
      word_cnt_q <= word_cnt_q + 1'b1;
    end
  end

  assign word_cnt = word_cnt_q;
`else
  // CNT_WIDTH only sizes the counter; keep it referenced when the counter is absent.
  logic [CNT_WIDTH-1:0] unused_cnt_width;
  assign unused_cnt_width = '0;
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Self-checking bench for fifo_rd_stream: queue-based FIFO model plus scoreboard reference.
module tb_fifo_rd_stream;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned DEPTH = 2;
  localparam int unsigned CNT_W = 4;

  logic             r_clk = 1'b0;
  logic             reset = 1'b0;
  logic             r_empty = 1'b1;
  logic [WIDTH-1:0] r_data = '0;
  logic             destination_r_en;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [1:0]       buf_level;
`ifdef RD_WORD_CNT_EN
  logic [CNT_W-1:0] word_cnt;
`endif

  int checks = 0;
  int failures = 0;

  logic [WIDTH-1:0] fifo_q[$];     // words still inside the modelled FIFO
  logic [WIDTH-1:0] exp_q[$];      // words popped from the FIFO, not yet delivered
  logic [WIDTH-1:0] deliv_data[$]; // every word handed downstream, in order
  int               deliv_cyc[$];
  int               m_level = 0;
  bit               m_inflight = 1'b0;
  int               m_cnt = 0;
  int               delivered = 0;
  int               cyc = 0;

  fifo_rd_stream #(
    .WIDTH     (WIDTH),
    .BUF_DEPTH (DEPTH),
    .CNT_WIDTH (CNT_W)
  ) dut (
    .r_clk            (r_clk),
    .reset            (reset),
    .r_data           (r_data),
    .r_empty          (r_empty),
    .destination_r_en (destination_r_en),
    .out_data         (out_data),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .buf_level        (buf_level)
`ifdef RD_WORD_CNT_EN
    ,
    .word_cnt         (word_cnt)
`endif
  );

  always #5 r_clk = ~r_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // FIFO with one-cycle read latency and a registered empty flag.
  always @(posedge r_clk or negedge reset) begin
    if (!reset) begin
      r_empty <= 1'b1;
    end else begin
      if (destination_r_en && !r_empty) r_data <= fifo_q.pop_front();
      r_empty <= (fifo_q.size() == 0);
    end
  end

  // Reference model: occupancy and credit from the stream rules, data order from the FIFO order.
  always @(negedge r_clk) begin
    bit pop_m;
    bit exp_en;
    cyc++;
    if (!reset) begin
      m_level = 0;
      m_inflight = 1'b0;
      m_cnt = 0;
      exp_q.delete();
    end else begin
      pop_m  = (m_level != 0) && out_ready;
      exp_en = !r_empty && ((m_level + int'(m_inflight) - int'(pop_m)) < DEPTH);
      check("dest_en", destination_r_en, exp_en);
      check("out_valid", out_valid, m_level != 0);
      check("buf_level", buf_level, m_level);
      if (m_level != 0) check("out_data", out_data, exp_q[0]);
`ifdef RD_WORD_CNT_EN
      check("word_cnt", word_cnt, m_cnt % (1 << CNT_W));
`endif
      if (pop_m) begin
        void'(exp_q.pop_front());
        deliv_data.push_back(out_data);
        deliv_cyc.push_back(cyc);
        delivered++;
        m_cnt++;
      end
      if (exp_en) begin
        if (fifo_q.size() == 0) check("fifo_underrun", 1, 0);
        else exp_q.push_back(fifo_q[0]);
      end
      m_level    = m_level + int'(m_inflight) - int'(pop_m);
      m_inflight = exp_en;
    end
  end

  task automatic wait_deliv(input int target, input int budget, input string tag);
    int n = 0;
    while (delivered < target && n < budget) begin
      @(posedge r_clk);
      n++;
    end
    check({tag, "_done"}, delivered >= target, 1);
    #1;
  endtask

  initial begin
    int base;
    int n;
    bit found;

    repeat (3) @(posedge r_clk);
    #1 reset = 1'b1;

    // 1: idle with an empty FIFO
    repeat (10) begin
      @(negedge r_clk); #1;
      check("t1_en", destination_r_en, 0);
      check("t1_valid", out_valid, 0);
      check("t1_level", buf_level, 0);
    end

    // 2: 8 words, continuous ready -> back-to-back delivery
    @(posedge r_clk); #1;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) fifo_q.push_back(8'h11 + 8'(i));
    base = delivered;
    wait_deliv(base + 8, 40, "t2");
    if (deliv_data.size() >= base + 8) begin
      for (int i = 0; i < 8; i++) check("t2_data", deliv_data[base + i], 8'h11 + 8'(i));
      check("t2_nobubble", deliv_cyc[base + 7] - deliv_cyc[base], 7);
    end
    repeat (3) @(posedge r_clk);
    #1 check("t2_drained", out_valid, 0);

    // 3: stalled consumer -> exactly two pops, then ordered drain
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) fifo_q.push_back(8'h11 + 8'(i));
    repeat (8) @(posedge r_clk);
    #1;
    check("t3_level", buf_level, 2);
    check("t3_en", destination_r_en, 0);
    check("t3_pops", fifo_q.size(), 6);
    check("t3_head", out_data, 8'h11);
    @(posedge r_clk); #1;
    check("t3_stable", out_data, 8'h11);
    base = delivered;
    out_ready = 1'b1;
    wait_deliv(base + 8, 40, "t3");
    if (deliv_data.size() >= base + 8)
      for (int i = 0; i < 8; i++) check("t3_data", deliv_data[base + i], 8'h11 + 8'(i));

    // 4: toggling ready, 5 words
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) fifo_q.push_back(8'hA0 + 8'(i));
    base = delivered;
    n = 0;
    while (delivered < base + 5 && n < 60) begin
      @(posedge r_clk); #1;
      out_ready = ~out_ready;
      n++;
    end
    check("t4_done", delivered >= base + 5, 1);
    if (deliv_data.size() >= base + 5)
      for (int i = 0; i < 5; i++) check("t4_data", deliv_data[base + i], 8'hA0 + 8'(i));
    repeat (3) @(posedge r_clk);
    #1;
    check("t4_fifo_empty", fifo_q.size(), 0);
    check("t4_no_extra", delivered, base + 5);

    // random traffic
    repeat (400) begin
      @(posedge r_clk); #1;
      if ($urandom_range(0, 2) != 0 && fifo_q.size() < 12) fifo_q.push_back(8'($urandom));
      out_ready = ($urandom_range(0, 3) != 0);
    end
    out_ready = 1'b1;
    n = 0;
    while ((fifo_q.size() != 0 || exp_q.size() != 0) && n < 100) begin
      @(posedge r_clk);
      n++;
    end
    #1 check("rand_drained", (fifo_q.size() == 0) && (exp_q.size() == 0), 1);

    // 5: reset while words are buffered and inflight
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) fifo_q.push_back(8'hC0 + 8'(i));
    found = 1'b0;
    n = 0;
    while (!found && n < 20) begin
      @(posedge r_clk); #1;
      found = (buf_level == 2'd1);
      n++;
    end
    check("t5_reached", found, 1);
    #2 reset = 1'b0;
    #1;
    check("t5_rst_valid", out_valid, 0);
    check("t5_rst_level", buf_level, 0);
    check("t5_rst_data", out_data, 0);
    check("t5_rst_en", destination_r_en, 0);
`ifdef RD_WORD_CNT_EN
    check("t5_rst_cnt", word_cnt, 0);
`endif
    fifo_q.delete();
    repeat (3) @(posedge r_clk);
    #1 reset = 1'b1;
    out_ready = 1'b1;
    repeat (10) begin
      @(negedge r_clk); #1;
      check("t5_no_ghost", out_valid, 0);
    end

`ifdef RD_WORD_CNT_EN
    // 6: 17 words through a 4-bit counter wraps to 1
    for (int i = 0; i < 17; i++) fifo_q.push_back(8'(i));
    base = delivered;
    wait_deliv(base + 17, 60, "t6");
    repeat (2) @(posedge r_clk);
    #1 check("t6_wrap", word_cnt, 1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
